serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial N-bit subtractor: D = A − B − Bin, computed one bit per clock, LSB first, through a single registered borrow stage. It is the inverse-direction companion to the one-bit full-adder cell. It serves as the area-minimal difference/compare unit for datapaths where latency is cheaper than a ripple array. Operands are captured on a start handshake and the result is presented with a one-cycle done pulse.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled on rising clk edges while busy=0.
- A  input  WIDTH  minuend; captured on the accepting edge.
- B  input  WIDTH  subtrahend; captured on the accepting edge.
- Bin  input  1  borrow-in; captured on the accepting edge.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; result is valid from this cycle on.
- D  output  WIDTH  difference, registered.
- Bo  output  1  borrow-out from the MSB; 1 means unsigned A < B + Bin.
- V  output  1  signed overflow of A − B − Bin, two's complement.

## Operation
- FSM has three states: IDLE, SHIFT, DONE.
  - IDLE → SHIFT on start=1.
  - DONE → SHIFT on start=1; otherwise DONE → IDLE.
  - SHIFT → DONE when bit counter = WIDTH−1.
- busy = (state==SHIFT). done = (state==DONE).
- Acceptance: start=1 at an edge with busy=0, i.e. in IDLE or DONE. On acceptance:
  - load A and B into internal shift registers;
  - set the borrow flop to Bin;
  - clear the bit counter, sized $clog2(WIDTH).
- start while busy=1 is ignored and not queued. A, B and Bin may change freely after acceptance.
- Per SHIFT cycle, with a = A_sh[0], b = B_sh[0], br = borrow flop:
  - d = a ^ b ^ br
  - br_next = (~a & b) | (~a & br) | (b & br)
  - d shifts into the MSB of the result shift register; A_sh and B_sh shift right; counter increments.
- Completion is on the SHIFT edge with counter = WIDTH−1. On that edge:
  - D ← the full assembled difference, including the final d;
  - Bo ← br_next;
  - V ← (A_cap[MSB] ≠ B_cap[MSB]) & (d_final ≠ A_cap[MSB]), where A_cap and B_cap are the captured MSBs held in a flop.
- D, Bo and V change only on completion edges. They hold their values through IDLE and through any following computation until the next completion.
- The internal partial result is never visible on D.

## Timing
- Reset (rst_n=0, asynchronous) forces:
  - state=IDLE, busy=0, done=0;
  - D=0, Bo=0, V=0;
  - counter, shift registers and borrow flop = 0.
- Reset release is synchronous to clk in the usual way; the first accept can occur at the first edge after rst_n rises.
- For an accepting edge k:
  - busy=1 during cycles k+1 … k+WIDTH, i.e. exactly WIDTH cycles;
  - D/Bo/V update at edge k+WIDTH;
  - done=1 for exactly the one cycle after edge k+WIDTH.
- Latency from accepting edge to done is WIDTH cycles. Throughput is one operation per WIDTH+1 cycles when start is asserted during the done cycle. There is no idle cycle between done and the next busy.
- Reset asserted mid-SHIFT aborts the operation. No done is issued, and D/Bo/V return to 0.
- start held high continuously re-arms each time busy falls. The bench treats this as back-to-back operations on whatever A/B/Bin are present during the done cycle.

## Test plan
- WIDTH=8; A=0x05, B=0x03, Bin=0, start one cycle → busy for 8 cycles; done at accept+8; D=0x02, Bo=0, V=0.
- A=0x03, B=0x05, Bin=0 → D=0xFE, Bo=1, V=0. Then A=0x00, B=0x00, Bin=1 → D=0xFF, Bo=1, V=0.
- A=0x80, B=0x01, Bin=0 → D=0x7F, Bo=0, V=1. Then A=0x7F, B=0xFF, Bin=0 → D=0x80, Bo=1, V=1.
- Start 0x10−0x01, pulse start again at accept+3 with A=0xAA → ignored; result D=0x0F. Assert start during the done cycle with A=0x20, B=0x20 → busy next cycle; done 8 cycles later with D=0x00, Bo=0.
- Drop rst_n at accept+4 during 0x55−0x11 → busy, done, D, Bo, V all 0 immediately. After release, a new 0x09−0x04 yields D=0x05 with correct timing.
- Randomized 1000 ops for WIDTH=8 and WIDTH=13 against the reference model {Bo,D} = A − B − Bin (WIDTH+1-bit) and the V formula. D must be stable between done pulses.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: D = A - B - Bin, one bit per clock, LSB first.
// Operands captured on start; result, borrow-out and overflow registered with a done pulse.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bo,
    output logic             V
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res;
    logic             r_br;
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_d;
    logic             r_bo;
    logic             r_v;

    logic             w_a;
    logic             w_b;
    logic             w_d;
    logic             w_br_next;
    logic             w_last;
    logic [WIDTH-1:0] w_res_next;

    // One-bit full-subtractor cell on the current LSBs
    assign w_a        = r_a_sh[0];
    assign w_b        = r_b_sh[0];
    assign w_d        = w_a ^ w_b ^ r_br;
    assign w_br_next  = (~w_a & w_b) | (~w_a & r_br) | (w_b & r_br);
    assign w_last     = (r_cnt == CW'(WIDTH - 1));
    assign w_res_next = {w_d, r_res[WIDTH-1:1]};

    // Control FSM, datapath shift registers and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_res   <= '0;
            r_br    <= 1'b0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_d     <= '0;
            r_bo    <= 1'b0;
            r_v     <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state <= SHIFT;
                        r_busy  <= 1'b1;
                        r_a_sh  <= A;
                        r_b_sh  <= B;
                        r_br    <= Bin;
                        r_a_msb <= A[WIDTH-1];
                        r_b_msb <= B[WIDTH-1];
                        r_cnt   <= '0;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                SHIFT: begin
                    r_a_sh <= r_a_sh >> 1;
                    r_b_sh <= r_b_sh >> 1;
                    r_res  <= w_res_next;
                    r_br   <= w_br_next;
                    r_cnt  <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_d     <= w_res_next;
                        r_bo    <= w_br_next;
                        r_v     <= (r_a_msb ^ r_b_msb) & (w_d ^ r_a_msb);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign D    = r_d;
    assign Bo   = r_bo;
    assign V    = r_v;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8): timing, results, ignored start,
// mid-operation reset and back-to-back operations against a reference model.
module tb_serial_subtractor;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] D;
    logic             Bo;
    logic             V;

    int               errors;
    int               checks;
    logic [WIDTH-1:0] last_d;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .busy  (busy),
        .done  (done),
        .D     (D),
        .Bo    (Bo),
        .V     (V)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present operands with start for one edge, then scramble the inputs
    task automatic accept(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
        A     = a;
        B     = b;
        Bin   = bin;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        A     = WIDTH'($urandom);
        B     = WIDTH'($urandom);
        Bin   = 1'($urandom);
    endtask

    // Called 1ns after the accepting edge; checks WIDTH busy cycles then the done cycle.
    // poke_at > 0 pulses start with A=0xAA during that busy cycle, which must be ignored.
    task automatic finish_op(input string tag, input logic [WIDTH-1:0] exp_d,
                             input logic exp_bo, input logic exp_v, input int poke_at);
        for (int c = 1; c <= int'(WIDTH); c++) begin
            chk({tag, " busy"}, 32'(busy), 32'd1);
            chk({tag, " done_low"}, 32'(done), 32'd0);
            chk({tag, " d_hold"}, 32'(D), 32'(last_d));
            if (c == poke_at) begin
                start = 1'b1;
                A     = 8'hAA;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " busy_low"}, 32'(busy), 32'd0);
        chk({tag, " D"}, 32'(D), 32'(exp_d));
        chk({tag, " Bo"}, 32'(Bo), 32'(exp_bo));
        chk({tag, " V"}, 32'(V), 32'(exp_v));
        last_d = exp_d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rbin;
        logic [WIDTH:0]   ref_full;
        logic             ref_v;

        errors = 0;
        checks = 0;
        last_d = '0;
        rst_n  = 1'b0;
        start  = 1'b0;
        A      = '0;
        B      = '0;
        Bin    = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst D", 32'(D), 32'd0);
        chk("rst Bo", 32'(Bo), 32'd0);
        chk("rst V", 32'(V), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        accept(8'h05, 8'h03, 1'b0);
        finish_op("05-03", 8'h02, 1'b0, 1'b0, 0);
        @(posedge clk);
        #1;
        chk("idle done_low", 32'(done), 32'd0);
        chk("idle D_hold", 32'(D), 32'h02);

        accept(8'h03, 8'h05, 1'b0);
        finish_op("03-05", 8'hFE, 1'b1, 1'b0, 0);
        accept(8'h00, 8'h00, 1'b1);
        finish_op("00-00-1", 8'hFF, 1'b1, 1'b0, 0);
        accept(8'h80, 8'h01, 1'b0);
        finish_op("80-01", 8'h7F, 1'b0, 1'b1, 0);
        accept(8'h7F, 8'hFF, 1'b0);
        finish_op("7F-FF", 8'h80, 1'b1, 1'b1, 0);

        // Start while busy is ignored; start during done re-arms with no gap
        accept(8'h10, 8'h01, 1'b0);
        finish_op("10-01 ign", 8'h0F, 1'b0, 1'b0, 3);
        accept(8'h20, 8'h20, 1'b0);
        finish_op("20-20 b2b", 8'h00, 1'b0, 1'b0, 0);
        @(posedge clk);
        #1;

        // Reset during SHIFT aborts and clears outputs
        accept(8'h55, 8'h11, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort D", 32'(D), 32'd0);
        chk("abort Bo", 32'(Bo), 32'd0);
        chk("abort V", 32'(V), 32'd0);
        last_d = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst done", 32'(done), 32'd0);
        accept(8'h09, 8'h04, 1'b0);
        finish_op("09-04", 8'h05, 1'b0, 1'b0, 0);

        // Back-to-back operands against the (WIDTH+1)-bit reference subtraction
        for (int n = 0; n < 40; n++) begin
            ra       = WIDTH'($urandom);
            rb       = WIDTH'($urandom);
            rbin     = 1'($urandom);
            ref_full = {1'b0, ra} - {1'b0, rb} - (WIDTH + 1)'(rbin);
            ref_v    = (ra[WIDTH-1] != rb[WIDTH-1]) && (ref_full[WIDTH-1] != ra[WIDTH-1]);
            accept(ra, rb, rbin);
            finish_op("rand", ref_full[WIDTH-1:0], ref_full[WIDTH], ref_v, 0);
        end

        @(posedge clk);
        #1;
        chk("final idle busy", 32'(busy), 32'd0);
        chk("final idle done", 32'(done), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
